// File: rtl/fifo_reader.sv
// fifo_reader
//   Drain-side companion of the multi-port fifo. Pops up to READ entries per
//   pop from the fifo read window into a local holding buffer, then serializes
//   them as a single-lane valid/ready stream towards a single-beat consumer.
//
// Parameters
//   DATA  width of one entry
//   READ  fifo read-port count (>= 1)
//   ACT   active level of re (0: active-low, 1: active-high)
//   CNTW  width of beat_cnt (only with FIFO_READER_STAT_EN)
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous reset, active-high
//   flush_     active-low synchronous clear of the holding buffer
//   rd         fifo read data, lane 0 = oldest
//   v          fifo read valid, prefix-contiguous from lane 0
//   re         fifo read enable, polarity set by ACT
//   out_valid  output beat valid
//   out_ready  consumer accepts beat
//   out_data   output beat data
//   busy       holding buffer non-empty
//   beat_cnt   delivered-beat counter (only with FIFO_READER_STAT_EN)
//
// Configuration
//   FIFO_READER_STAT_EN  adds the beat_cnt port and its counter; cleared by
//                        reset only, wraps modulo 2^CNTW.

module fifo_reader #(
  parameter int DATA = 64,
  parameter int READ = 4,
  parameter int ACT  = 0
`ifdef FIFO_READER_STAT_EN
  , parameter int CNTW = 32
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_,
  input  logic [READ-1:0][DATA-1:0]  rd,
  input  logic [READ-1:0]            v,
  output logic [READ-1:0]            re,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA-1:0]            out_data,
  output logic                       busy
`ifdef FIFO_READER_STAT_EN
  , output logic [CNTW-1:0]          beat_cnt
`endif
);

  localparam int   CW      = $clog2(READ + 1);
  localparam int   HW      = (READ > 1) ? $clog2(READ) : 1;
  localparam logic ACT_LVL = (ACT != 0);

  logic [READ-1:0][DATA-1:0] hbuf;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             pop_n;
  logic [HW-1:0]             head;
  logic                      load;
  logic                      fire;

  // Number of entries the fifo currently offers; v is prefix-contiguous, so
  // the offered entries occupy lanes 0..pop_n-1.
  always_comb begin
    pop_n = '0;
    for (int i = 0; i < READ; i++) begin
      pop_n = pop_n + CW'(v[i]);
    end
  end

  assign out_valid = (cnt != '0);
  assign busy      = out_valid;
  assign out_data  = hbuf[head];
  assign fire      = out_valid & out_ready;

  // Refill when the buffer is empty, or when its last beat is leaving this
  // cycle, so consecutive windows stream without a bubble.
  assign load = flush_ & ~reset & ((cnt == '0) | ((cnt == CW'(1)) & out_ready));

  // Pop exactly the offered lanes, and only on a load.
  always_comb begin
    re = '0;
    for (int i = 0; i < READ; i++) begin
      re[i] = (load & v[i]) ? ACT_LVL : ~ACT_LVL;
    end
  end

  // Holding buffer state. A load overrides the fire update because the beat
  // leaving in the same cycle is the last one of the previous window. Flush
  // leaves hbuf contents in place; only cnt/head matter for visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      hbuf <= '0;
      cnt  <= '0;
      head <= '0;
    end else if (!flush_) begin
      cnt  <= '0;
      head <= '0;
    end else if (load) begin
      head <= '0;
      cnt  <= pop_n;
      for (int i = 0; i < READ; i++) begin
        if (CW'(i) < pop_n) begin
          hbuf[i] <= rd[i];
        end
      end
    end else if (fire) begin
      head <= head + HW'(1);
      cnt  <= cnt - CW'(1);
    end
  end

`ifdef FIFO_READER_STAT_EN
  // Delivered-beat statistic; a beat taken during a flush cycle still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (fire) begin
      beat_cnt <= beat_cnt + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader
//   Self-checking bench for fifo_reader. A queue models the upstream fifo and
//   a second queue models the beats still owed to the consumer; expected re,
//   out_valid, out_data, busy and beat_cnt are derived from those queues.

module tb_fifo_reader;

  localparam int DATA = 64;
  localparam int READ = 4;
  localparam int ACT  = 0;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush_;
  logic [READ-1:0][DATA-1:0] rd;
  logic [READ-1:0]           v;
  logic [READ-1:0]           re;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA-1:0]           out_data;
  logic                      busy;
`ifdef FIFO_READER_STAT_EN
  logic [31:0]               beat_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Upstream fifo contents (oldest first) and beats owed downstream.
  logic [DATA-1:0] src[$];
  logic [DATA-1:0] owed[$];
  bit              zeroKnown;
  logic [31:0]     beatsExp;

  // Current step inputs, mirrored for the model.
  logic curRs, curFl, curRdy;

  always #5 clk = ~clk;

  fifo_reader #(
    .DATA(DATA),
    .READ(READ),
    .ACT (ACT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush_   (flush_),
    .rd       (rd),
    .v        (v),
    .re       (re),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
`ifdef FIFO_READER_STAT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  // One comparison with its immediate assertion.
  task automatic check(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs; the fifo window shows the oldest entries.
  task automatic applyStimulus(input logic rs, input logic fl, input logic rdy);
    int n;
    n = (src.size() > READ) ? READ : src.size();
    curRs = rs; curFl = fl; curRdy = rdy;
    reset = rs; flush_ = fl; out_ready = rdy;
    for (int i = 0; i < READ; i++) begin
      if (i < n) begin
        v[i]  = 1'b1;
        rd[i] = src[i];
      end else begin
        v[i]  = 1'b0;
        rd[i] = {$urandom, $urandom};
      end
    end
    assert (((v + 1'b1) & v) == '0) else $error("[TB] protocol violation, non-prefix v %b", v);
  endtask

  // Compare outputs against the queues, then advance the model across the edge.
  task automatic checkOutput(input string tag);
    logic            ld;
    logic            fire;
    logic [READ-1:0] mask;
    logic [READ-1:0] reExp;
    int              n;
    #1;
    ld    = curFl && !curRs && (owed.size() == 0 || (owed.size() == 1 && curRdy));
    mask  = ld ? v : '0;
    reExp = (ACT != 0) ? mask : ~mask;
    check({tag, ".re"}, DATA'(re), DATA'(reExp));
    check({tag, ".out_valid"}, DATA'(out_valid), DATA'(owed.size() != 0));
    check({tag, ".busy"}, DATA'(busy), DATA'(owed.size() != 0));
    if (owed.size() != 0) check({tag, ".out_data"}, out_data, owed[0]);
    else if (zeroKnown)   check({tag, ".out_data0"}, out_data, '0);
`ifdef FIFO_READER_STAT_EN
    check({tag, ".beat_cnt"}, DATA'(beat_cnt), DATA'(beatsExp));
`endif
    fire = (owed.size() != 0) && curRdy;
    if (curRs) begin
      owed.delete();
      beatsExp  = '0;
      zeroKnown = 1'b1;
    end else begin
      if (fire) beatsExp = beatsExp + 1;
      if (!curFl) begin
        owed.delete();
      end else if (ld) begin
        owed.delete();
        n = $countones(mask);
        for (int i = 0; i < n; i++) owed.push_back(src.pop_front());
        if (n > 0) zeroKnown = 1'b0;
      end else if (fire) begin
        void'(owed.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic rs, input logic fl, input logic rdy);
    applyStimulus(rs, fl, rdy);
    checkOutput(tag);
  endtask

  task automatic pushN(input int n, input logic [DATA-1:0] base);
    for (int i = 0; i < n; i++) src.push_back(base + DATA'(i));
  endtask

  initial begin
    reset = 1'b1; flush_ = 1'b1; out_ready = 1'b0; v = '0; rd = '0;
    zeroKnown = 1'b1; beatsExp = '0;
    @(negedge clk);

    // Reset with a full window offered: nothing may be popped.
    pushN(4, 64'hAAAA_0000_0000_0000);
    step("reset0", 1'b1, 1'b1, 1'b0);
    step("reset1", 1'b1, 1'b1, 1'b0);
    src.delete();

    // Single pop of three entries, serialized A,B,C then idle.
    pushN(3, 64'h0000_0000_0000_00A0);
    for (int i = 0; i < 5; i++) step("single", 1'b0, 1'b1, 1'b1);

    // Two back-to-back full windows stream eight beats without a bubble.
    pushN(8, 64'h0000_0000_0000_0D00);
    for (int i = 0; i < 10; i++) step("zerobubble", 1'b0, 1'b1, 1'b1);

    // Backpressure holds the beat stable, then three beats drain in order.
    pushN(3, 64'h0000_0000_0000_0B00);
    step("bp_load", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("bp_hold", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("bp_drain", 1'b0, 1'b1, 1'b1);

    // Flush with two beats held and no consumer: E,F are dropped.
    pushN(2, 64'h0000_0000_0000_0E00);
    step("fl_load", 1'b0, 1'b1, 1'b0);
    step("fl_flush", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("fl_after", 1'b0, 1'b1, 1'b0);

    // Ten delivered beats survive a flush, then reset clears the count.
    step("stat_rst", 1'b1, 1'b1, 1'b0);
    pushN(10, 64'h0000_0000_0000_5000);
    for (int i = 0; i < 12; i++) step("stat_run", 1'b0, 1'b1, 1'b1);
    step("stat_flush", 1'b0, 1'b0, 1'b1);
    step("stat_post", 1'b0, 1'b1, 1'b0);
`ifdef FIFO_READER_STAT_EN
    check("stat_ten", DATA'(beat_cnt), DATA'(10));
`endif
    step("stat_rst2", 1'b1, 1'b1, 1'b0);
    step("stat_zero", 1'b0, 1'b1, 1'b0);

    // Randomized traffic: bursty producer, random consumer, occasional flush/reset.
    for (int c = 0; c < 400; c++) begin
      if (src.size() < 12) begin
        int k;
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) src.push_back({$urandom, $urandom});
      end
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
